// File: rtl/hilo_div_unit_if.sv
// Signal bundle between the EX/WB pipeline side (master) and hilo_div_unit (slave).
interface hilo_div_unit_if;
  logic [65:0] hilo_bus;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stall_req;

  modport master (
    output hilo_bus, div_start, div_signed, div_opa, div_opb, div_annul,
    input  hi_rdata, lo_rdata, div_result, div_ready, stall_req
  );

  modport slave (
    input  hilo_bus, div_start, div_signed, div_opa, div_opb, div_annul,
    output hi_rdata, lo_rdata, div_result, div_ready, stall_req
  );
endinterface

// File: rtl/hilo_div_unit.sv
// Architectural HI/LO registers plus iterative restoring DIV/DIVU engine.
// Define HILO_BYPASS_EN to forward same-cycle WB writes straight to hi_rdata/lo_rdata.
module hilo_div_unit #(
  parameter int DIV_CYCLES = 32
) (
  input logic            clk,
  input logic            rst,
  hilo_div_unit_if.slave bus_io
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic [31:0] hi_q, lo_q;

  assign {hi_we, lo_we, hi_wdata, lo_wdata} = bus_io.hilo_bus;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

`ifdef HILO_BYPASS_EN
  assign bus_io.hi_rdata = hi_we ? hi_wdata : hi_q;
  assign bus_io.lo_rdata = lo_we ? lo_wdata : lo_q;
`else
  assign bus_io.hi_rdata = hi_q;
  assign bus_io.lo_rdata = lo_q;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      divisor_q, divisor_d;
  logic             signA_q, signA_d;
  logic             signB_q, signB_d;
  logic [63:0]      result_q, result_d;

  logic        startOk;
  logic        negA, negB;
  logic [32:0] shifted;
  logic        stepOk;
  logic [31:0] stepRem, stepQuot;
  logic [31:0] finalRem, finalQuot;

  assign startOk = bus_io.div_start & ~bus_io.div_annul;
  assign negA    = bus_io.div_signed & bus_io.div_opa[31];
  assign negB    = bus_io.div_signed & bus_io.div_opb[31];

  // Restoring step: the partial remainder never exceeds the divisor, so 33 bits hold the shifted value.
  assign shifted   = {rem_q, quot_q[31]};
  assign stepOk    = shifted >= {1'b0, divisor_q};
  assign stepRem   = stepOk ? 32'(shifted - {1'b0, divisor_q}) : shifted[31:0];
  assign stepQuot  = {quot_q[30:0], stepOk};
  assign finalQuot = (signA_q ^ signB_q) ? -stepQuot : stepQuot;
  assign finalRem  = signA_q ? -stepRem : stepRem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (startOk) begin
          if (bus_io.div_opb == 32'd0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d   = S_ON;
            cnt_d     = '0;
            rem_d     = '0;
            quot_d    = negA ? -bus_io.div_opa : bus_io.div_opa;
            divisor_d = negB ? -bus_io.div_opb : bus_io.div_opb;
            signA_d   = negA;
            signB_d   = negB;
          end
        end
      end
      S_DIVZERO: begin
        if (bus_io.div_annul) begin
          state_d = S_IDLE;
        end else begin
          result_d = '0;
          state_d  = S_END;
        end
      end
      S_ON: begin
        if (bus_io.div_annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = stepRem;
          quot_d = stepQuot;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            result_d = {finalRem, finalQuot};
            state_d  = S_END;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      result_q  <= result_d;
    end
  end

  assign bus_io.div_result = result_q;
  assign bus_io.div_ready  = (state_q == S_END);
  assign bus_io.stall_req  = ((state_q == S_IDLE) & startOk) |
                             (state_q == S_DIVZERO) | (state_q == S_ON);

endmodule

// File: tb/tb_hilo_div_unit.sv
// Randomized self-checking bench for hilo_div_unit against an arithmetic reference model.
module tb_hilo_div_unit;
  logic clk = 1'b0;
  logic rst;

  hilo_div_unit_if bus ();

  hilo_div_unit #(.DIV_CYCLES(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expHi;
  logic [31:0] expLo;
  logic [63:0] lastResult;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, with the two special cases.
  function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    q  = sq;
    r  = sr;
    return {r, q};
  endfunction

  task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] expRes, got;
    int          expCycle, readyCycle, badStall, extraReady;
    expRes     = refDiv(sgn, a, b);
    expCycle   = (b == 32'd0) ? 2 : 33;
    readyCycle = -1;
    badStall   = -1;
    extraReady = 0;
    got        = '0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      bus.div_start  = (readyCycle < 0);
      bus.div_signed = sgn;
      bus.div_opa    = a;
      bus.div_opb    = b;
      #1;
      if (bus.stall_req !== (c < expCycle) && badStall < 0) badStall = c;
      if (bus.div_ready === 1'b1) begin
        if (readyCycle < 0) begin
          readyCycle = c;
          got        = bus.div_result;
        end else begin
          extraReady++;
        end
      end
    end
    bus.div_start = 1'b0;
    checkOutput("readyCycle", 64'(readyCycle), 64'(expCycle));
    checkOutput("divResult", got, expRes);
    checkOutput("stallBadCycle", 64'(badStall), {64{1'b1}});
    checkOutput("extraReady", 64'(extraReady), 64'd0);
    checkOutput("resultHold", bus.div_result, expRes);
    lastResult = expRes;
  endtask

  task automatic hiloCycle(input logic [65:0] v);
    logic [31:0] eh, el;
    @(negedge clk);
    bus.hilo_bus = v;
    #1;
`ifdef HILO_BYPASS_EN
    eh = v[65] ? v[63:32] : expHi;
    el = v[64] ? v[31:0]  : expLo;
`else
    eh = expHi;
    el = expLo;
`endif
    checkOutput("hiRdata", 64'(bus.hi_rdata), 64'(eh));
    checkOutput("loRdata", 64'(bus.lo_rdata), 64'(el));
    if (v[65]) expHi = v[63:32];
    if (v[64]) expLo = v[31:0];
  endtask

  task automatic annulTest();
    int badStall, readyCount;
    badStall   = -1;
    readyCount = 0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      bus.div_signed = 1'b0;
      bus.div_opa    = 32'd100;
      bus.div_opb    = 32'd7;
      bus.div_start  = (c < 10);
      bus.div_annul  = (c == 10);
      #1;
      if (bus.stall_req !== (c <= 10) && badStall < 0) badStall = c;
      if (bus.div_ready === 1'b1) readyCount++;
    end
    bus.div_annul = 1'b0;
    checkOutput("annulStallBadCycle", 64'(badStall), {64{1'b1}});
    checkOutput("annulReadyCount", 64'(readyCount), 64'd0);
    checkOutput("annulResultHold", bus.div_result, lastResult);
  endtask

  task automatic resetTest();
    int readyCount;
    readyCount = 0;
    hiloCycle({2'b11, 32'hABCD_0001, 32'h1234_5678});
    hiloCycle(66'd0);
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      bus.div_signed = 1'b0;
      bus.div_opa    = 32'd1000;
      bus.div_opb    = 32'd3;
      bus.div_start  = (c < 15);
      rst            = (c == 15);
      #1;
      if (bus.div_ready === 1'b1) readyCount++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstReadyBefore", 64'(readyCount), 64'd0);
    checkOutput("rstHi", 64'(bus.hi_rdata), 64'd0);
    checkOutput("rstLo", 64'(bus.lo_rdata), 64'd0);
    checkOutput("rstStall", 64'(bus.stall_req), 64'd0);
    checkOutput("rstReady", 64'(bus.div_ready), 64'd0);
    checkOutput("rstResult", bus.div_result, 64'd0);
    expHi      = '0;
    expLo      = '0;
    lastResult = '0;
    applyStimulus(1'b0, 32'd9, 32'd3);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          sgn;
    rst            = 1'b1;
    bus.hilo_bus   = '0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_opa    = '0;
    bus.div_opb    = '0;
    bus.div_annul  = 1'b0;
    expHi          = '0;
    expLo          = '0;
    lastResult     = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetHi", 64'(bus.hi_rdata), 64'd0);
    checkOutput("resetLo", 64'(bus.lo_rdata), 64'd0);
    checkOutput("resetResult", bus.div_result, 64'd0);
    checkOutput("resetReady", 64'(bus.div_ready), 64'd0);
    checkOutput("resetStall", 64'(bus.stall_req), 64'd0);
    rst = 1'b0;

    hiloCycle({2'b11, 32'hDEAD_BEEF, 32'h0000_CAFE});
    hiloCycle(66'd0);
    hiloCycle({2'b10, 32'h1111_1111, 32'h2222_2222});
    hiloCycle(66'd0);
    hiloCycle({2'b01, 32'h3333_3333, 32'h4444_4444});
    for (int i = 0; i < 12; i++)
      hiloCycle({2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom)});
    hiloCycle(66'd0);

    applyStimulus(1'b0, 32'd7, 32'd2);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(1'b0, 32'h0000_1234, 32'd0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 20; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      applyStimulus(sgn, a, b);
    end

    annulTest();
    applyStimulus(1'b0, 32'd100, 32'd7);
    resetTest();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Consumer end of the WB-stage `hilo_bus`: holds the architectural HI/LO registers and commits WB writes to them.
- Serves HI/LO reads to EX (MFHI/MFLO).
- Contains the iterative 32-cycle DIV/DIVU engine that EX drives. While a divide runs, the engine raises a stall request toward the pipeline stall controller.

Parameters:
- DIV_CYCLES, 32, number of restoring-division iterations; must equal the operand width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- hilo_bus  in  66  from WB: {hi_we[65], lo_we[64], hi_wdata[63:32], lo_wdata[31:0]}
- hi_rdata  out  32  current HI value to EX
- lo_rdata  out  32  current LO value to EX
- div_start  in  1  EX requests a divide; held high until div_ready
- div_signed  in  1  1 = DIV, 0 = DIVU
- div_opa  in  32  dividend
- div_opb  in  32  divisor
- div_annul  in  1  cancel an in-flight divide (exception/flush)
- div_result  out  64  {remainder[63:32], quotient[31:0]}
- div_ready  out  1  div_result valid, one-cycle pulse
- stall_req  out  1  to stall controller; freezes EX and earlier stages

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: hi = 0, lo = 0, div_result = 0, div_ready = 0, stall_req = 0, FSM = IDLE, counter = 0. Reset mid-divide aborts immediately and produces no ready pulse.
- HI/LO write:
  - At posedge, if hi_we then hi <= hi_wdata.
  - Independently, if lo_we then lo <= lo_wdata.
  - hilo_bus all zeros (a WB bubble) writes nothing.
- HI/LO read: hi_rdata/lo_rdata = registered hi/lo (see optional feature for bypass).
- FSM states: IDLE, DIVZERO, ON, END.
  - IDLE:
    - div_start & ~div_annul & div_opb == 0 -> DIVZERO.
    - div_start & ~div_annul & div_opb != 0 -> ON. On this transition:
      - latch |opa| and |opb| (absolute values only when div_signed);
      - latch the operand sign bits;
      - clear the partial remainder;
      - counter = 0.
  - DIVZERO: result register = 64'h0 -> END.
  - ON:
    - One restoring step per cycle: shift {rem, quot} left 1; trial subtract divisor; if non-negative, keep the difference and set quotient LSB.
    - counter increments each step; after step DIV_CYCLES-1 -> END.
    - On entry to END, apply sign correction when div_signed:
      - negate the quotient if the operand signs differ;
      - the remainder takes the dividend's sign.
  - END: div_ready = 1 for exactly this cycle, div_result stable -> IDLE unconditionally.
- stall_req = (state == IDLE & div_start & ~div_annul) | state == DIVZERO | state == ON. It is low in END, so the divide instruction leaves EX in the cycle after END.
- Latency, non-zero divisor: start sampled in IDLE at cycle 0; ON occupies cycles 1..32; END and div_ready at cycle 33.
- Latency, zero divisor: DIVZERO at cycle 1; END and div_ready at cycle 2.
- div_annul in any state other than IDLE -> IDLE next cycle, no div_ready pulse, stall_req low from that next cycle. div_annul in END is ignored (the ready pulse is already issued).
- div_start seen while in DIVZERO/ON/END is ignored; no restart.
- div_result holds its value until the next END; it is not cleared on return to IDLE.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (mod-2^32 arithmetic, no trap).
- The divide engine never writes HI/LO itself. The result travels EX->MEM->WB and returns through hilo_bus.

Optional Feature:
- HILO_BYPASS_EN defined:
  - hi_rdata = hi_we ? hi_wdata : hi; lo_rdata likewise.
  - A same-cycle WB write is visible to EX combinationally.
- Not defined: hi_rdata/lo_rdata come from registers only, so a write becomes visible the cycle after it. The hazard is then handled by stall logic outside this block.

Test Plan:
- Unsigned 7/2:
  - Stimulus: div_start=1, div_signed=0, opa=7, opb=2 at cycle 0.
  - Response: stall_req high cycles 0..32; div_ready only at cycle 33; div_result = {32'h1, 32'h3}.
- Signed -7/2:
  - Stimulus: opa=0xFFFFFFF9, opb=2, div_signed=1.
  - Response: at cycle 33 quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
- Divide by zero:
  - Stimulus: opa=0x1234, opb=0.
  - Response: div_ready at cycle 2; div_result = 64'h0; stall_req high cycles 0..1 only.
- Annul mid-divide:
  - Stimulus: div_annul pulsed at cycle 10 of a divide.
  - Response: FSM back in IDLE at cycle 11; stall_req low from cycle 11; no div_ready through cycle 40.
- HI/LO write and read:
  - Stimulus: hilo_bus = {1, 1, 32'hDEADBEEF, 32'h0000CAFE}.
  - Response with HILO_BYPASS_EN: rdata equals the new values in the same cycle.
  - Response without HILO_BYPASS_EN: new values appear the next cycle.
  - Stimulus: hi_we only.
  - Response: lo unchanged.
- Reset mid-divide:
  - Stimulus: rst=1 at cycle 15 of a divide.
  - Response at the next edge: hi = lo = 0, stall_req = 0, div_ready = 0, div_result = 0. A fresh 9/3 divide afterwards yields {0, 3} at cycle 33.
